// File: rtl/riscv_mem_responder.sv
`timescale 1ns/1ps
// riscv_mem_responder
// Unified instruction/data memory responder for the multicycle RISC-V core.
// Instruction words (32-bit) and data doublewords (64-bit) live in separate
// arrays. Writes complete at the acceptance edge. Reads take READ_LATENCY
// cycles, during which busy is high and any new request is rejected.
//
// Ports:
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   memread, memwrite - level-sampled request strobes
//   adr               - byte address
//   Data_in           - write data (bits [31:0] only for instruction writes)
//   IorD              - 0 = instruction region, 1 = data region
//   Override          - allows writes into the instruction region (program load)
//   Data_out          - read data, instruction reads zero-extended; holds between reads
//   busy              - read in flight
//   valid             - one-cycle pulse when Data_out is updated
//   err               - one-cycle pulse when a request is rejected
module riscv_mem_responder #(
    parameter int IMEM_WORDS   = 256,
    parameter int DMEM_WORDS   = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [63:0] adr,
    input  logic [63:0] Data_in,
    input  logic        IorD,
    input  logic        Override,
    output logic [63:0] Data_out,
    output logic        busy,
    output logic        valid,
    output logic        err
);

    localparam int IIDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int DIDX_W = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
    localparam int CNT_W  = $clog2(READ_LATENCY + 1);

    typedef enum logic {
        IDLE,
        READ_WAIT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               rd_iord;
    logic [IIDX_W-1:0]  rd_iidx;
    logic [DIDX_W-1:0]  rd_didx;
    logic               err_defer;

    logic [31:0] imem [IMEM_WORDS];
    logic [63:0] dmem [DMEM_WORDS];

    logic              req;
    logic              misaligned;
    logic              out_of_range;
    logic              bad;
    logic              wr_ok;
    logic              rd_ok;
    logic [IIDX_W-1:0] iidx;
    logic [DIDX_W-1:0] didx;

    // Request decode: every rejection reason folds into 'bad'. The full
    // upper address is compared so huge addresses never alias into range.
    always_comb begin
        req          = memread | memwrite;
        misaligned   = IorD ? (adr[2:0] != 3'b000) : (adr[1:0] != 2'b00);
        out_of_range = IorD ? (adr[63:3] >= 61'(DMEM_WORDS))
                            : (adr[63:2] >= 62'(IMEM_WORDS));
        bad          = misaligned | out_of_range | (memread & memwrite)
                     | (memwrite & ~IorD & ~Override);
        wr_ok        = (state == IDLE) & memwrite & ~bad;
        rd_ok        = (state == IDLE) & memread & ~bad;
        iidx         = adr[IIDX_W+1:2];
        didx         = adr[DIDX_W+2:3];
    end

    // Storage arrays: not reset, contents undefined until written.
    always_ff @(posedge clk) begin
        if (wr_ok && IorD) begin
            dmem[didx] <= Data_in;
        end
        if (wr_ok && !IorD) begin
            imem[iidx] <= Data_in[31:0];
        end
    end

    // Control FSM with registered outputs. A request arriving on the
    // completion edge is still rejected, but its err pulse is pushed one
    // cycle later so that valid and err never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_iord   <= 1'b0;
            rd_iidx   <= '0;
            rd_didx   <= '0;
            err_defer <= 1'b0;
            Data_out  <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            err       <= 1'b0;
        end else begin
            valid     <= 1'b0;
            err       <= err_defer;
            err_defer <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && bad) begin
                        err <= 1'b1;
                    end else if (rd_ok) begin
                        state   <= READ_WAIT;
                        cnt     <= CNT_W'(READ_LATENCY - 1);
                        busy    <= 1'b1;
                        rd_iord <= IorD;
                        rd_iidx <= iidx;
                        rd_didx <= didx;
                    end
                end
                READ_WAIT: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        valid    <= 1'b1;
                        Data_out <= rd_iord ? dmem[rd_didx] : {32'h0, imem[rd_iidx]};
                        if (req) begin
                            err_defer <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (req) begin
                            err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_responder.sv
`timescale 1ns/1ps
// tb_riscv_mem_responder
// Two responders (READ_LATENCY 2 and 1) share one request bus. A directed
// vector table exercises the latency-2 instance, hand sequences cover the
// latency-1 and mid-read reset corners, and a randomized phase compares
// both instances against a transaction-level reference model.
module tb_riscv_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memwrite;
    logic        memread;
    logic [63:0] adr;
    logic [63:0] Data_in;
    logic        IorD;
    logic        Override;

    logic [63:0] dout_w  [2];
    logic        busy_w  [2];
    logic        valid_w [2];
    logic        err_w   [2];

    int n_compared   = 0;
    int n_mismatched = 0;

    // 100 MHz clock
    always #5 clk = ~clk;

    riscv_mem_responder #(
        .IMEM_WORDS(256), .DMEM_WORDS(256), .READ_LATENCY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .memwrite(memwrite), .memread(memread),
        .adr(adr), .Data_in(Data_in), .IorD(IorD), .Override(Override),
        .Data_out(dout_w[0]), .busy(busy_w[0]), .valid(valid_w[0]), .err(err_w[0])
    );

    riscv_mem_responder #(
        .IMEM_WORDS(256), .DMEM_WORDS(256), .READ_LATENCY(1)
    ) dut_l1 (
        .clk(clk), .rst_n(rst_n), .memwrite(memwrite), .memread(memread),
        .adr(adr), .Data_in(Data_in), .IorD(IorD), .Override(Override),
        .Data_out(dout_w[1]), .busy(busy_w[1]), .valid(valid_w[1]), .err(err_w[1])
    );

    // Directed vector record: inputs held for one edge, outputs expected after it
    typedef struct {
        logic        rd;
        logic        wr;
        logic [63:0] a;
        logic [63:0] d;
        logic        iord;
        logic        ovr;
        logic        ev;
        logic        eb;
        logic        ee;
        logic [63:0] ed;
    } vec_t;

    vec_t vecs[$];

    // Reference model state, one slot per instance
    int          lat [2];
    int          cyc;
    bit          m_pend    [2];
    int          m_done_at [2];
    bit          m_region  [2];
    int          m_idx     [2];
    bit          m_defer   [2];
    logic [63:0] m_dout    [2];
    logic [31:0] m_imem    [2][256];
    logic [63:0] m_dmem    [2][256];
    bit          e_valid   [2];
    bit          e_err     [2];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [63:0] a,
                                 input logic [63:0] d, input logic iord, input logic ovr);
        memread  = rd;
        memwrite = wr;
        adr      = a;
        Data_in  = d;
        IorD     = iord;
        Override = ovr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d,
                          input logic iord, input logic ovr, input logic ev, input logic eb,
                          input logic ee, input logic [63:0] ed);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.iord = iord; v.ovr = ovr;
        v.ev = ev; v.eb = eb; v.ee = ee; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic modelReset();
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = 1'b0;
            m_defer[k] = 1'b0;
            m_dout[k]  = 64'h0;
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        modelReset();
    endtask

    // Transaction-level model: a read accepted at cycle c completes at
    // c + latency; requests while a read is outstanding are rejected, with
    // the err pulse of a completion-cycle collision reported a cycle later.
    task automatic modelStep(input int k);
        bit              req;
        bit              ok;
        longint unsigned gran;
        longint unsigned idx;
        req        = memread || memwrite;
        e_valid[k] = 1'b0;
        e_err[k]   = m_defer[k];
        m_defer[k] = 1'b0;
        if (m_pend[k] && cyc == m_done_at[k]) begin
            e_valid[k] = 1'b1;
            m_pend[k]  = 1'b0;
            m_dout[k]  = m_region[k] ? m_dmem[k][m_idx[k]] : {32'h0, m_imem[k][m_idx[k]]};
            if (req) m_defer[k] = 1'b1;
        end else if (m_pend[k]) begin
            if (req) e_err[k] = 1'b1;
        end else if (req) begin
            gran = IorD ? 64'd8 : 64'd4;
            idx  = adr / gran;
            ok   = !(memread && memwrite) && (adr % gran == 0) && (idx < 256)
                   && !(memwrite && !IorD && !Override);
            if (!ok) begin
                e_err[k] = 1'b1;
            end else if (memwrite) begin
                if (IorD) m_dmem[k][int'(idx)] = Data_in;
                else      m_imem[k][int'(idx)] = Data_in[31:0];
            end else begin
                m_pend[k]    = 1'b1;
                m_done_at[k] = cyc + lat[k];
                m_region[k]  = IorD;
                m_idx[k]     = int'(idx);
            end
        end
    endtask

    task automatic modelCycle();
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        cyc++;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("rnd%0d.L%0d.valid", cyc, lat[k]), 64'(valid_w[k]), 64'(e_valid[k]));
            checkOutput($sformatf("rnd%0d.L%0d.err", cyc, lat[k]), 64'(err_w[k]), 64'(e_err[k]));
            checkOutput($sformatf("rnd%0d.L%0d.busy", cyc, lat[k]), 64'(busy_w[k]), 64'(m_pend[k]));
            checkOutput($sformatf("rnd%0d.L%0d.dout", cyc, lat[k]), dout_w[k], m_dout[k]);
        end
    endtask

    initial begin
        logic [63:0] inst_word;
        logic [63:0] dbl;
        inst_word = 64'h0000_0000_0057_8833;
        dbl       = 64'hDEAD_BEEF_CAFE_F00D;
        lat[0] = 2;
        lat[1] = 1;

        // Reset state
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("reset.L%0d.dout", lat[k]), dout_w[k], 64'h0);
            checkOutput($sformatf("reset.L%0d.busy", lat[k]), 64'(busy_w[k]), 64'h0);
            checkOutput($sformatf("reset.L%0d.valid", lat[k]), 64'(valid_w[k]), 64'h0);
            checkOutput($sformatf("reset.L%0d.err", lat[k]), 64'(err_w[k]), 64'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed table for the latency-2 instance
        //     rd    wr    adr      data                    iord  ovr   ev    eb    ee    Data_out
        addVec(1'b0, 1'b1, 64'd24,  64'd100,                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        addVec(1'b1, 1'b0, 64'd24,  64'd0,                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd100);
        addVec(1'b0, 1'b1, 64'd0,   64'h0057_8833,          1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd100);
        addVec(1'b1, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd100);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd100);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, inst_word);
        addVec(1'b0, 1'b1, 64'd0,   64'hFFFF_FFFF,          1'b0, 1'b0, 1'b0, 1'b0, 1'b1, inst_word);
        addVec(1'b1, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, inst_word);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, inst_word);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, inst_word);
        addVec(1'b1, 1'b0, 64'd20,  64'd0,                  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, inst_word);
        addVec(1'b1, 1'b1, 64'd24,  64'd55,                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, inst_word);
        addVec(1'b1, 1'b0, 64'd24,  64'd0,                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, inst_word);
        addVec(1'b0, 1'b1, 64'd24,  64'd7,                  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, inst_word);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd100);
        addVec(1'b1, 1'b0, 64'd2048, 64'd0,                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'd100);
        addVec(1'b1, 1'b0, 64'd1024, 64'd0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd100);
        addVec(1'b0, 1'b1, 64'd8,   dbl,                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd100);
        addVec(1'b1, 1'b0, 64'd8,   64'd0,                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd100);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd100);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, dbl);
        addVec(1'b1, 1'b0, 64'd8,   64'd0,                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, dbl);
        addVec(1'b1, 1'b0, 64'd8,   64'd0,                  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, dbl);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, dbl);
        addVec(1'b1, 1'b0, 64'd2,   64'd0,                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, dbl);
        addVec(1'b0, 1'b1, 64'd16,  64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, dbl);
        addVec(1'b1, 1'b0, 64'd16,  64'd0,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, dbl);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, dbl);
        addVec(1'b0, 1'b0, 64'd0,   64'd0,                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h9ABC_DEF0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].iord, vecs[i].ovr);
            tick();
            checkOutput($sformatf("vec%0d.valid", i), 64'(valid_w[0]), 64'(vecs[i].ev));
            checkOutput($sformatf("vec%0d.busy", i), 64'(busy_w[0]), 64'(vecs[i].eb));
            checkOutput($sformatf("vec%0d.err", i), 64'(err_w[0]), 64'(vecs[i].ee));
            checkOutput($sformatf("vec%0d.dout", i), dout_w[0], vecs[i].ed);
        end

        // Latency-1 instance: valid on E0+1, collision on the completion edge
        doReset();
        applyStimulus(1'b0, 1'b1, 64'd24, 64'd100, 1'b1, 1'b0);
        tick();
        checkOutput("l1.wr.busy", 64'(busy_w[1]), 64'h0);
        checkOutput("l1.wr.err", 64'(err_w[1]), 64'h0);
        applyStimulus(1'b1, 1'b0, 64'd24, 64'd0, 1'b1, 1'b0);
        tick();
        checkOutput("l1.e0.busy", 64'(busy_w[1]), 64'h1);
        checkOutput("l1.e0.valid", 64'(valid_w[1]), 64'h0);
        applyStimulus(1'b0, 1'b1, 64'd24, 64'd7, 1'b1, 1'b0);
        tick();
        checkOutput("l1.e1.valid", 64'(valid_w[1]), 64'h1);
        checkOutput("l1.e1.busy", 64'(busy_w[1]), 64'h0);
        checkOutput("l1.e1.err", 64'(err_w[1]), 64'h0);
        checkOutput("l1.e1.dout", dout_w[1], 64'd100);
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        tick();
        checkOutput("l1.e2.err", 64'(err_w[1]), 64'h1);
        checkOutput("l1.e2.valid", 64'(valid_w[1]), 64'h0);
        checkOutput("l2.e2.valid", 64'(valid_w[0]), 64'h1);
        checkOutput("l2.e2.dout", dout_w[0], 64'd100);
        applyStimulus(1'b1, 1'b0, 64'd24, 64'd0, 1'b1, 1'b0);
        tick();
        checkOutput("l1.reread.busy", 64'(busy_w[1]), 64'h1);
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        tick();
        checkOutput("l1.reread.valid", 64'(valid_w[1]), 64'h1);
        checkOutput("l1.reread.dout", dout_w[1], 64'd100);
        tick();

        // Reset in the middle of a read
        applyStimulus(1'b1, 1'b0, 64'd24, 64'd0, 1'b1, 1'b0);
        tick();
        checkOutput("rstmid.L2.busy_before", 64'(busy_w[0]), 64'h1);
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("rstmid.L%0d.dout", lat[k]), dout_w[k], 64'h0);
            checkOutput($sformatf("rstmid.L%0d.busy", lat[k]), 64'(busy_w[k]), 64'h0);
            checkOutput($sformatf("rstmid.L%0d.valid", lat[k]), 64'(valid_w[k]), 64'h0);
            checkOutput($sformatf("rstmid.L%0d.err", lat[k]), 64'(err_w[k]), 64'h0);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("rstmid.post%0d.L%0d.valid", c, lat[k]), 64'(valid_w[k]), 64'h0);
                checkOutput($sformatf("rstmid.post%0d.L%0d.busy", c, lat[k]), 64'(busy_w[k]), 64'h0);
            end
        end

        // Randomized phase against the reference model
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 64'(i * 4), {$urandom, $urandom}, 1'b0, 1'b1);
            modelCycle();
            applyStimulus(1'b0, 1'b1, 64'(i * 8), {$urandom, $urandom}, 1'b1, 1'b0);
            modelCycle();
        end
        for (int n = 0; n < 1500; n++) begin
            int          op;
            int          kind;
            logic        iord;
            logic [63:0] a;
            longint      gran;
            op   = $urandom_range(0, 9);
            kind = $urandom_range(0, 9);
            iord = 1'($urandom_range(0, 1));
            gran = iord ? 8 : 4;
            if (kind == 0)      a = 64'($urandom_range(0, 7) * gran + $urandom_range(1, 3));
            else if (kind == 1) a = 64'((256 + $urandom_range(0, 3)) * gran);
            else if (kind == 2) a = {1'b1, 60'($urandom), 3'b000};
            else                a = 64'($urandom_range(0, 7) * gran);
            applyStimulus((op >= 4 && op <= 6) || op == 9, (op == 7 || op == 8) || op == 9,
                          a, {$urandom, $urandom}, iord, 1'($urandom_range(0, 1)));
            modelCycle();
        end
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) modelCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
